udp_tx_dbg_tap: RTL and testbench

Passive monitor on the UDP TX byte stream (valid/ready handshake with sop/eop framing). It produces registered, debug-ready statistics and sticky error flags. Its outputs feed the on-chip logic-analyzer wrapper probe inputs directly, one output per probe, widths matched. It never drives or modifies the monitored stream.

---
 rtl/udp_dbg_pkg.sv | 17 +
 rtl/udp_dbg_stall_mon.sv | 38 +++
 rtl/udp_tx_dbg_tap.sv | 159 +++++++++++++++
 tb/tb_udp_tx_dbg_tap.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/udp_dbg_pkg.sv
// Shared types and default widths for the UDP TX debug tap.
// Passive monitor: no latency or backpressure on the monitored stream.
package udp_dbg_pkg;

  localparam int TS_W_DEF        = 40;
  localparam int CNT_W_DEF       = 32;
  localparam int LEN_W_DEF       = 15;
  localparam int STALL_LIMIT_DEF = 1024;

  localparam logic [LEN_W_DEF-1:0] LEN_MAX = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

endpackage

// File: rtl/udp_dbg_stall_mon.sv
// Raises a sticky flag once valid&!ready persists for STALL_LIMIT consecutive cycles.
// Flag is registered (1 cycle after the limiting cycle); never backpressures the stream.
module udp_dbg_stall_mon #(
  parameter int STALL_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic s_valid,
  input  logic s_ready,
  output logic err_stall
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STALL_LIMIT);

  logic [SW-1:0] stall_cnt;
  logic          stalled;

  assign stalled = s_valid & ~s_ready;

  // Counter parks at LIMIT so a very long stall cannot wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      err_stall <= 1'b0;
    end else if (clr) begin
      stall_cnt <= '0;
      err_stall <= 1'b0;
    end else if (stalled) begin
      if (stall_cnt != LIMIT) stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == LIMIT - 1'b1) err_stall <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule

// File: rtl/udp_tx_dbg_tap.sv
// Passive UDP TX stream tap: registered packet/byte statistics and sticky framing errors.
// All outputs lag the observed beat by 1 cycle; the monitored stream is never driven.
module udp_tx_dbg_tap
  import udp_dbg_pkg::*;
#(
  parameter int TS_W        = TS_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s_valid,
  input  logic             s_ready,
  input  logic             s_sop,
  input  logic             s_eop,
  output logic [TS_W-1:0]  dbg_ts,
  output logic             dbg_valid,
  output logic             dbg_ready,
  output logic             dbg_sop,
  output logic             dbg_eop,
  output logic [CNT_W-1:0] dbg_pkt_cnt,
  output logic [LEN_W-1:0] dbg_pkt_len,
  output logic [CNT_W-1:0] dbg_byte_cnt,
  output logic             err_sop_in_pkt,
  output logic             err_eop_no_pkt,
  output logic             err_len_ovf,
  output logic             err_stall,
  output logic [TS_W-1:0]  dbg_last_ts
);

  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d, cur_len_inc;
  logic [CNT_W-1:0] pkt_cnt_d, byte_cnt_d;
  logic [LEN_W-1:0] pkt_len_d;
  logic [TS_W-1:0]  last_ts_d;
  logic             err_sop_d, err_eop_d, err_ovf_d;
  logic             beat;

  assign beat        = s_valid & s_ready;
  assign cur_len_inc = (cur_len_q == LEN_SAT) ? LEN_SAT : cur_len_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cur_len_d  = cur_len_q;
    pkt_cnt_d  = dbg_pkt_cnt;
    pkt_len_d  = dbg_pkt_len;
    byte_cnt_d = dbg_byte_cnt;
    last_ts_d  = dbg_last_ts;
    err_sop_d  = err_sop_in_pkt;
    err_eop_d  = err_eop_no_pkt;
    err_ovf_d  = err_len_ovf;

    if (clr) begin
      // clr wins over a coincident beat; that beat is dropped entirely.
      state_d    = IDLE;
      cur_len_d  = '0;
      pkt_cnt_d  = '0;
      pkt_len_d  = '0;
      byte_cnt_d = '0;
      last_ts_d  = '0;
      err_sop_d  = 1'b0;
      err_eop_d  = 1'b0;
      err_ovf_d  = 1'b0;
    end else if (beat) begin
      byte_cnt_d = dbg_byte_cnt + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (s_sop && s_eop) begin
            pkt_cnt_d = dbg_pkt_cnt + 1'b1;
            pkt_len_d = LEN_W'(1);
            last_ts_d = dbg_ts;
          end else if (s_sop) begin
            cur_len_d = LEN_W'(1);
            state_d   = IN_PKT;
          end else if (s_eop) begin
            err_eop_d = 1'b1;
          end
        end
        IN_PKT: begin
          if (cur_len_q == LEN_SAT) err_ovf_d = 1'b1;
          if (s_sop) begin
            // Restart: the open packet is abandoned without being counted.
            err_sop_d = 1'b1;
            cur_len_d = LEN_W'(1);
            if (s_eop) begin
              pkt_cnt_d = dbg_pkt_cnt + 1'b1;
              pkt_len_d = LEN_W'(1);
              last_ts_d = dbg_ts;
              cur_len_d = '0;
              state_d   = IDLE;
            end
          end else if (s_eop) begin
            pkt_cnt_d = dbg_pkt_cnt + 1'b1;
            pkt_len_d = cur_len_inc;
            last_ts_d = dbg_ts;
            cur_len_d = '0;
            state_d   = IDLE;
          end else begin
            cur_len_d = cur_len_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_ts         <= '0;
      dbg_valid      <= 1'b0;
      dbg_ready      <= 1'b0;
      dbg_sop        <= 1'b0;
      dbg_eop        <= 1'b0;
      cur_len_q      <= '0;
      dbg_pkt_cnt    <= '0;
      dbg_pkt_len    <= '0;
      dbg_byte_cnt   <= '0;
      dbg_last_ts    <= '0;
      err_sop_in_pkt <= 1'b0;
      err_eop_no_pkt <= 1'b0;
      err_len_ovf    <= 1'b0;
    end else begin
      dbg_ts         <= dbg_ts + 1'b1;
      dbg_valid      <= s_valid;
      dbg_ready      <= s_ready;
      dbg_sop        <= s_sop & beat;
      dbg_eop        <= s_eop & beat;
      cur_len_q      <= cur_len_d;
      dbg_pkt_cnt    <= pkt_cnt_d;
      dbg_pkt_len    <= pkt_len_d;
      dbg_byte_cnt   <= byte_cnt_d;
      dbg_last_ts    <= last_ts_d;
      err_sop_in_pkt <= err_sop_d;
      err_eop_no_pkt <= err_eop_d;
      err_len_ovf    <= err_ovf_d;
    end
  end

  udp_dbg_stall_mon #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_mon (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .err_stall(err_stall)
  );

endmodule

// File: tb/tb_udp_tx_dbg_tap.sv
// Directed bench for udp_tx_dbg_tap: vector table plus hand-written long-packet, stall and reset sequences.
module tb_udp_tx_dbg_tap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        s_valid = 1'b0, s_ready = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
  logic [39:0] dbg_ts, dbg_last_ts;
  logic        dbg_valid, dbg_ready, dbg_sop, dbg_eop;
  logic [31:0] dbg_pkt_cnt, dbg_byte_cnt;
  logic [14:0] dbg_pkt_len;
  logic        err_sop_in_pkt, err_eop_no_pkt, err_len_ovf, err_stall;

  int checks = 0;
  int errors = 0;
  logic [39:0] ts_model;
  logic [39:0] exp_last;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) ts_model <= '0;
    else     ts_model <= ts_model + 1'b1;
  end

  udp_tx_dbg_tap dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_sop(s_sop), .s_eop(s_eop),
    .dbg_ts(dbg_ts), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_sop(dbg_sop), .dbg_eop(dbg_eop),
    .dbg_pkt_cnt(dbg_pkt_cnt), .dbg_pkt_len(dbg_pkt_len), .dbg_byte_cnt(dbg_byte_cnt),
    .err_sop_in_pkt(err_sop_in_pkt), .err_eop_no_pkt(err_eop_no_pkt),
    .err_len_ovf(err_len_ovf), .err_stall(err_stall),
    .dbg_last_ts(dbg_last_ts)
  );

  typedef struct {
    logic        c, v, r, s, e;
    logic [31:0] pkt;
    logic [14:0] len;
    logic [31:0] bytes;
    logic [3:0]  flg;   // {sop_in_pkt, eop_no_pkt, len_ovf, stall}
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic c, v, r, s, e, input int pkt, len, bytes, input logic [3:0] flg);
    vec_t t;
    t.c = c; t.v = v; t.r = r; t.s = s; t.e = e;
    t.pkt = 32'(pkt); t.len = 15'(len); t.bytes = 32'(bytes); t.flg = flg;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, v, r, s, e);
    clr = c; s_valid = v; s_ready = r; s_sop = s; s_eop = e;
  endtask

  function automatic logic [3:0] flags();
    return {err_sop_in_pkt, err_eop_no_pkt, err_len_ovf, err_stall};
  endfunction

  initial begin
    // Reset state and free-running timestamp
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_ts", 64'(dbg_ts), 64'd10);
    chk("reset_pkt_cnt", 64'(dbg_pkt_cnt), 64'd0);
    chk("reset_byte_cnt", 64'(dbg_byte_cnt), 64'd0);
    chk("reset_pkt_len", 64'(dbg_pkt_len), 64'd0);
    chk("reset_flags", 64'(flags()), 64'd0);
    chk("reset_last_ts", 64'(dbg_last_ts), 64'd0);

    // 64-byte packet, ready always high
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 1'b1, 1'b1, i == 0, i == 63);
      if (i == 63) exp_last = ts_model;
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p64_pkt_cnt", 64'(dbg_pkt_cnt), 64'd1);
    chk("p64_pkt_len", 64'(dbg_pkt_len), 64'd64);
    chk("p64_byte_cnt", 64'(dbg_byte_cnt), 64'd64);
    chk("p64_last_ts", 64'(dbg_last_ts), 64'(exp_last));
    chk("p64_flags", 64'(flags()), 64'd0);

    // Table: single-beat + toggling-ready 3-byte packet, sop-in-packet, lone eop, clr with eop
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    tbl[1]  = mk(0, 1, 1, 1, 1, 1, 1, 1, 4'b0000);
    tbl[2]  = mk(0, 1, 1, 1, 0, 1, 1, 2, 4'b0000);
    tbl[3]  = mk(0, 1, 0, 0, 0, 1, 1, 2, 4'b0000);
    tbl[4]  = mk(0, 1, 1, 0, 0, 1, 1, 3, 4'b0000);
    tbl[5]  = mk(0, 1, 0, 0, 1, 1, 1, 3, 4'b0000);
    tbl[6]  = mk(0, 1, 1, 0, 1, 2, 3, 4, 4'b0000);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    tbl[8]  = mk(0, 1, 1, 1, 0, 0, 0, 1, 4'b0000);
    tbl[9]  = mk(0, 1, 1, 0, 0, 0, 0, 5, 4'b0000);
    tbl[9].bytes = 32'd2;
    tbl[10] = mk(0, 1, 1, 0, 0, 0, 0, 3, 4'b0000);
    tbl[11] = mk(0, 1, 1, 1, 0, 0, 0, 4, 4'b1000);
    tbl[12] = mk(0, 1, 1, 0, 1, 1, 2, 5, 4'b1000);
    tbl[13] = mk(0, 1, 1, 0, 1, 1, 2, 6, 4'b1100);
    tbl[14] = mk(1, 1, 1, 0, 1, 0, 0, 0, 4'b0000);
    tbl[15] = mk(0, 1, 1, 0, 1, 0, 0, 1, 4'b0100);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].c, tbl[i].v, tbl[i].r, tbl[i].s, tbl[i].e);
      @(negedge clk);
      chk($sformatf("vec%0d_pkt_cnt", i), 64'(dbg_pkt_cnt), 64'(tbl[i].pkt));
      chk($sformatf("vec%0d_pkt_len", i), 64'(dbg_pkt_len), 64'(tbl[i].len));
      chk($sformatf("vec%0d_byte_cnt", i), 64'(dbg_byte_cnt), 64'(tbl[i].bytes));
      chk($sformatf("vec%0d_flags", i), 64'(flags()), 64'(tbl[i].flg));
      chk($sformatf("vec%0d_sop", i), 64'(dbg_sop), 64'(tbl[i].s & tbl[i].v & tbl[i].r));
      chk($sformatf("vec%0d_eop", i), 64'(dbg_eop), 64'(tbl[i].e & tbl[i].v & tbl[i].r));
      chk($sformatf("vec%0d_ts", i), 64'(dbg_ts), 64'(ts_model));
      if (tbl[i].c) chk($sformatf("vec%0d_last_ts", i), 64'(dbg_last_ts), 64'd0);
    end

    // 40000-byte packet: length saturates, overflow raised on byte 32768
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 40000; i++) begin
      drive(1'b0, 1'b1, 1'b1, i == 0, i == 39999);
      @(negedge clk);
      if (i == 32766) chk("ovf_before_limit", 64'(err_len_ovf), 64'd0);
      if (i == 32767) chk("ovf_at_limit", 64'(err_len_ovf), 64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("long_len_ovf", 64'(err_len_ovf), 64'd1);
    chk("long_pkt_len", 64'(dbg_pkt_len), 64'd32767);
    chk("long_pkt_cnt", 64'(dbg_pkt_cnt), 64'd1);
    chk("long_byte_cnt", 64'(dbg_byte_cnt), 64'd40000);

    // Stall: 1023 cycles quiet, 1024th raises the flag
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (1023) @(negedge clk);
    chk("stall_1023", 64'(err_stall), 64'd0);
    @(negedge clk);
    chk("stall_1024", 64'(err_stall), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("stall_sticky", 64'(err_stall), 64'd1);

    // Async reset mid-packet
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ts", 64'(dbg_ts), 64'd0);
    chk("arst_byte_cnt", 64'(dbg_byte_cnt), 64'd0);
    chk("arst_pkt_cnt", 64'(dbg_pkt_cnt), 64'd0);
    chk("arst_flags", 64'(flags()), 64'd0);
    chk("arst_valid", 64'(dbg_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_idle_eop", 64'(err_eop_no_pkt), 64'd1);
    chk("post_rst_pkt_cnt", 64'(dbg_pkt_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
